// File: rtl/mc_ctrl.sv
// mc_ctrl: main control FSM for a multicycle MIPS-subset datapath.
// Build macro MC_CTRL_ILLEGAL_TRAP_EN: undefined instructions trap to HALT with Illegal set.
`ifndef ALU_ADD
`define ALU_ADD  4'd0
`define ALU_SUB  4'd1
`define ALU_AND  4'd2
`define ALU_OR   4'd3
`define ALU_XOR  4'd4
`define ALU_NOR  4'd5
`define ALU_SLT  4'd6
`define ALU_SLTU 4'd7
`define ALU_SLL  4'd8
`define ALU_SRL  4'd9
`define ALU_SRA  4'd10
`define ALU_LUI  4'd11
`endif

module mc_ctrl (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] Op,
    input  logic [5:0] Funct,
    input  logic [4:0] Rt,
    input  logic       Zero,
    input  logic       A_First,
    input  logic       A_Zero,
    output logic       PCWrite,
    output logic       IRWrite,
    output logic       MemWrite,
    output logic       RegWrite,
    output logic       IorD,
    output logic       ExtOp,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] PCSource,
    output logic [1:0] RegDst,
    output logic [1:0] MemtoReg,
    output logic [3:0] ALUOp,
    output logic [3:0] State,
    output logic       Illegal
);

    typedef enum logic [3:0] {
        FETCH    = 4'd0,  DECODE = 4'd1,  EXEC_R = 4'd2,  EXEC_I = 4'd3,
        MEM_ADDR = 4'd4,  MEM_RD = 4'd5,  MEM_WB = 4'd6,  MEM_WR = 4'd7,
        WB_R     = 4'd8,  WB_I   = 4'd9,  BRANCH = 4'd10, JUMP   = 4'd11,
        HALT     = 4'd12
    } state_t;

    state_t state, next_state;

    logic       r_alu, r_shamt, r_shvar, r_jr, r_jalr;
    logic       i_alu, i_sext, is_j, is_jal, is_branch, is_lw, is_sw;
    logic       br_taken;
    logic [3:0] r_op, i_op;

    // Instruction classification from the IR fields.
    always_comb begin : decode
        r_alu = 1'b0; r_shamt = 1'b0; r_shvar = 1'b0; r_jr = 1'b0; r_jalr = 1'b0;
        i_alu = 1'b0; i_sext = 1'b0; is_j = 1'b0; is_jal = 1'b0;
        is_branch = 1'b0; is_lw = 1'b0; is_sw = 1'b0;
        r_op = `ALU_ADD; i_op = `ALU_ADD;
        if (Op == 6'b000000) begin
            case (Funct)
                6'b100000, 6'b100001: begin r_alu = 1'b1;   r_op = `ALU_ADD;  end
                6'b100010, 6'b100011: begin r_alu = 1'b1;   r_op = `ALU_SUB;  end
                6'b100100:            begin r_alu = 1'b1;   r_op = `ALU_AND;  end
                6'b100101:            begin r_alu = 1'b1;   r_op = `ALU_OR;   end
                6'b100110:            begin r_alu = 1'b1;   r_op = `ALU_XOR;  end
                6'b100111:            begin r_alu = 1'b1;   r_op = `ALU_NOR;  end
                6'b101010:            begin r_alu = 1'b1;   r_op = `ALU_SLT;  end
                6'b101011:            begin r_alu = 1'b1;   r_op = `ALU_SLTU; end
                6'b000000:            begin r_shamt = 1'b1; r_op = `ALU_SLL;  end
                6'b000010:            begin r_shamt = 1'b1; r_op = `ALU_SRL;  end
                6'b000011:            begin r_shamt = 1'b1; r_op = `ALU_SRA;  end
                6'b000100:            begin r_shvar = 1'b1; r_op = `ALU_SLL;  end
                6'b000110:            begin r_shvar = 1'b1; r_op = `ALU_SRL;  end
                6'b000111:            begin r_shvar = 1'b1; r_op = `ALU_SRA;  end
                6'b001000:            r_jr   = 1'b1;
                6'b001001:            r_jalr = 1'b1;
                default:              ;
            endcase
        end
        case (Op)
            6'b000010:            is_j = 1'b1;
            6'b000011:            is_jal = 1'b1;
            6'b000100, 6'b000101,
            6'b000110, 6'b000111: is_branch = 1'b1;
            6'b000001:            is_branch = (Rt == 5'd0) || (Rt == 5'd1);
            6'b001000, 6'b001001: begin i_alu = 1'b1; i_sext = 1'b1; i_op = `ALU_ADD;  end
            6'b001010:            begin i_alu = 1'b1; i_sext = 1'b1; i_op = `ALU_SLT;  end
            6'b001011:            begin i_alu = 1'b1; i_sext = 1'b1; i_op = `ALU_SLTU; end
            6'b001100:            begin i_alu = 1'b1; i_op = `ALU_AND; end
            6'b001101:            begin i_alu = 1'b1; i_op = `ALU_OR;  end
            6'b001110:            begin i_alu = 1'b1; i_op = `ALU_XOR; end
            6'b001111:            begin i_alu = 1'b1; i_op = `ALU_LUI; end
            6'b100011:            is_lw = 1'b1;
            6'b101011:            is_sw = 1'b1;
            default:              ;
        endcase
    end

    // Branch condition from the ALU flags of the A-B compare.
    always_comb begin : branch_cond
        case (Op)
            6'b000100: br_taken = Zero;
            6'b000101: br_taken = !Zero;
            6'b000110: br_taken = A_First || A_Zero;
            6'b000111: br_taken = !A_First && !A_Zero;
            6'b000001: br_taken = (Rt == 5'd0) ? A_First : !A_First;
            default:   br_taken = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= FETCH;
        else     state <= next_state;
    end

    // Next-state and Moore outputs; reset masks every write enable.
    always_comb begin : fsm
        next_state = state;
        PCWrite = 1'b0; IRWrite = 1'b0; MemWrite = 1'b0; RegWrite = 1'b0;
        IorD = 1'b0; ExtOp = 1'b0; Illegal = 1'b0;
        ALUSrcA = 2'd0; ALUSrcB = 2'd0; PCSource = 2'd0; RegDst = 2'd0; MemtoReg = 2'd0;
        ALUOp = `ALU_ADD;
        case (state)
            FETCH: begin
                IRWrite = 1'b1; ALUSrcB = 2'd1; PCWrite = 1'b1;
                next_state = DECODE;
            end
            DECODE: begin
                ALUSrcB = 2'd3; ExtOp = 1'b1;
                if (r_alu || r_shamt || r_shvar)        next_state = EXEC_R;
                else if (r_jr || r_jalr || is_j || is_jal) next_state = JUMP;
                else if (is_branch)                     next_state = BRANCH;
                else if (i_alu)                         next_state = EXEC_I;
                else if (is_lw || is_sw)                next_state = MEM_ADDR;
                else begin
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
                    next_state = HALT;
`else
                    next_state = FETCH;
`endif
                end
            end
            EXEC_R: begin
                ALUSrcA = r_shamt ? 2'd2 : 2'd1; ALUOp = r_op;
                next_state = WB_R;
            end
            WB_R: begin
                RegDst = 2'd1; RegWrite = 1'b1;
                next_state = FETCH;
            end
            EXEC_I: begin
                ALUSrcA = 2'd1; ALUSrcB = 2'd2; ExtOp = i_sext; ALUOp = i_op;
                next_state = WB_I;
            end
            WB_I: begin
                RegWrite = 1'b1;
                next_state = FETCH;
            end
            MEM_ADDR: begin
                ALUSrcA = 2'd1; ALUSrcB = 2'd2; ExtOp = 1'b1;
                next_state = is_lw ? MEM_RD : MEM_WR;
            end
            MEM_RD: begin
                IorD = 1'b1;
                next_state = MEM_WB;
            end
            MEM_WB: begin
                MemtoReg = 2'd1; RegWrite = 1'b1;
                next_state = FETCH;
            end
            MEM_WR: begin
                IorD = 1'b1; MemWrite = 1'b1;
                next_state = FETCH;
            end
            BRANCH: begin
                ALUSrcA = 2'd1; ALUOp = `ALU_SUB; PCSource = 2'd1; PCWrite = br_taken;
                next_state = FETCH;
            end
            JUMP: begin
                PCWrite = 1'b1;
                if (is_j || is_jal) PCSource = 2'd2;
                else                PCSource = 2'd3;
                if (is_jal) begin
                    RegDst = 2'd2; MemtoReg = 2'd2; RegWrite = 1'b1;
                end else if (r_jalr) begin
                    RegDst = 2'd1; MemtoReg = 2'd2; RegWrite = 1'b1;
                end
                next_state = FETCH;
            end
            HALT: begin
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
                Illegal = 1'b1;
                next_state = HALT;
`else
                next_state = FETCH;
`endif
            end
            default: next_state = FETCH;
        endcase
        if (rst) begin
            PCWrite = 1'b0; IRWrite = 1'b0; MemWrite = 1'b0; RegWrite = 1'b0; Illegal = 1'b0;
        end
    end

    assign State = state;

endmodule

// File: tb/tb_mc_ctrl.sv
// Directed bench for mc_ctrl: walks each instruction class cycle by cycle.
`ifndef ALU_ADD
`define ALU_ADD  4'd0
`define ALU_SUB  4'd1
`define ALU_AND  4'd2
`define ALU_OR   4'd3
`define ALU_XOR  4'd4
`define ALU_NOR  4'd5
`define ALU_SLT  4'd6
`define ALU_SLTU 4'd7
`define ALU_SLL  4'd8
`define ALU_SRL  4'd9
`define ALU_SRA  4'd10
`define ALU_LUI  4'd11
`endif

module tb_mc_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] Op, Funct;
    logic [4:0] Rt;
    logic       Zero, A_First, A_Zero;
    logic       PCWrite, IRWrite, MemWrite, RegWrite, IorD, ExtOp, Illegal;
    logic [1:0] ALUSrcA, ALUSrcB, PCSource, RegDst, MemtoReg;
    logic [3:0] ALUOp, State;
    logic [24:0] obs;

    int checks = 0;
    int failures = 0;

    mc_ctrl dut (
        .clk(clk), .rst(rst), .Op(Op), .Funct(Funct), .Rt(Rt),
        .Zero(Zero), .A_First(A_First), .A_Zero(A_Zero),
        .PCWrite(PCWrite), .IRWrite(IRWrite), .MemWrite(MemWrite), .RegWrite(RegWrite),
        .IorD(IorD), .ExtOp(ExtOp), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .PCSource(PCSource), .RegDst(RegDst), .MemtoReg(MemtoReg), .ALUOp(ALUOp),
        .State(State), .Illegal(Illegal)
    );

    always #5 clk = ~clk;

    assign obs = {State, PCWrite, IRWrite, MemWrite, RegWrite, IorD, ExtOp, Illegal,
                  ALUSrcA, ALUSrcB, PCSource, RegDst, MemtoReg, ALUOp};

    // Expected control word: state, enables, selects, ALU op.
    function automatic logic [24:0] ev(
        input logic [3:0] st, input logic pcw, input logic irw, input logic mw,
        input logic rw, input logic iord, input logic ext, input logic ill,
        input logic [1:0] asa, input logic [1:0] asb, input logic [1:0] pcs,
        input logic [1:0] rd, input logic [1:0] m2r, input logic [3:0] aop);
        return {st, pcw, irw, mw, rw, iord, ext, ill, asa, asb, pcs, rd, m2r, aop};
    endfunction

    logic [24:0] fetch_v, decode_v, rst_v, halt_v;

    task automatic check(input string tag, input logic [24:0] got, input logic [24:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic nxt(input string tag, input logic [24:0] exp);
        @(posedge clk);
        #3;
        check(tag, obs, exp);
    endtask

    // Entered while in FETCH; loads IR fields and flags, checks FETCH and DECODE.
    task automatic begin_instr(input string tag, input logic [5:0] op, input logic [5:0] fn,
                               input logic [4:0] rt, input logic z, input logic af,
                               input logic az);
        Op = op; Funct = fn; Rt = rt; Zero = z; A_First = af; A_Zero = az;
        #1;
        check({tag, "_fetch"}, obs, fetch_v);
        nxt({tag, "_decode"}, decode_v);
    endtask

    task automatic branch_case(input string tag, input logic [5:0] op, input logic [4:0] rt,
                               input logic z, input logic af, input logic az, input logic taken);
        begin_instr(tag, op, 6'd0, rt, z, af, az);
        nxt({tag, "_branch"}, ev(4'd10, taken,0,0,0, 0,0,0, 2'd1,2'd0,2'd1,2'd0,2'd0, `ALU_SUB));
        nxt({tag, "_ret"}, fetch_v);
    endtask

    task automatic rtype_case(input string tag, input logic [5:0] fn, input logic [1:0] asa,
                              input logic [3:0] aop);
        begin_instr(tag, 6'b000000, fn, 5'd0, 0, 0, 0);
        nxt({tag, "_exec"}, ev(4'd2, 0,0,0,0, 0,0,0, asa,2'd0,2'd0,2'd0,2'd0, aop));
        nxt({tag, "_wb"},   ev(4'd8, 0,0,0,1, 0,0,0, 2'd0,2'd0,2'd0,2'd1,2'd0, `ALU_ADD));
        nxt({tag, "_ret"}, fetch_v);
    endtask

    task automatic itype_case(input string tag, input logic [5:0] op, input logic ext,
                              input logic [3:0] aop);
        begin_instr(tag, op, 6'd0, 5'd0, 0, 0, 0);
        nxt({tag, "_exec"}, ev(4'd3, 0,0,0,0, 0,ext,0, 2'd1,2'd2,2'd0,2'd0,2'd0, aop));
        nxt({tag, "_wb"},   ev(4'd9, 0,0,0,1, 0,0,0, 2'd0,2'd0,2'd0,2'd0,2'd0, `ALU_ADD));
        nxt({tag, "_ret"}, fetch_v);
    endtask

    task automatic jump_case(input string tag, input logic [5:0] op, input logic [5:0] fn,
                             input logic rw, input logic [1:0] pcs, input logic [1:0] rd,
                             input logic [1:0] m2r);
        begin_instr(tag, op, fn, 5'd0, 0, 0, 0);
        nxt({tag, "_jump"}, ev(4'd11, 1,0,0,rw, 0,0,0, 2'd0,2'd0,pcs,rd,m2r, `ALU_ADD));
        nxt({tag, "_ret"}, fetch_v);
    endtask

    task automatic illegal_case(input string tag, input logic [5:0] op, input logic [5:0] fn,
                                input logic [4:0] rt);
        begin_instr(tag, op, fn, rt, 0, 0, 0);
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
        nxt({tag, "_halt0"}, halt_v);
        nxt({tag, "_halt1"}, halt_v);
        nxt({tag, "_halt2"}, halt_v);
        rst = 1'b1;
        #1;
        check({tag, "_halt_rstmask"}, obs, ev(4'd12, 0,0,0,0, 0,0,0, 2'd0,2'd0,2'd0,2'd0,2'd0, `ALU_ADD));
        nxt({tag, "_rst_fetch"}, rst_v);
        rst = 1'b0;
        #1;
        check({tag, "_post_rst"}, obs, fetch_v);
`else
        nxt({tag, "_nop_ret"}, fetch_v);
`endif
    endtask

    initial begin
        fetch_v  = ev(4'd0, 1,1,0,0, 0,0,0, 2'd0,2'd1,2'd0,2'd0,2'd0, `ALU_ADD);
        decode_v = ev(4'd1, 0,0,0,0, 0,1,0, 2'd0,2'd3,2'd0,2'd0,2'd0, `ALU_ADD);
        rst_v    = ev(4'd0, 0,0,0,0, 0,0,0, 2'd0,2'd1,2'd0,2'd0,2'd0, `ALU_ADD);
        halt_v   = ev(4'd12, 0,0,0,0, 0,0,1, 2'd0,2'd0,2'd0,2'd0,2'd0, `ALU_ADD);

        rst = 1'b1; Op = 6'd0; Funct = 6'b100000; Rt = 5'd0;
        Zero = 1'b0; A_First = 1'b0; A_Zero = 1'b0;
        nxt("reset0", rst_v);
        nxt("reset1", rst_v);
        rst = 1'b0;
        #1;
        check("reset_release_fetch", obs, fetch_v);

        rtype_case("add",  6'b100000, 2'd1, `ALU_ADD);
        rtype_case("sub",  6'b100010, 2'd1, `ALU_SUB);
        rtype_case("nor",  6'b100111, 2'd1, `ALU_NOR);
        rtype_case("sltu", 6'b101011, 2'd1, `ALU_SLTU);
        rtype_case("sll",  6'b000000, 2'd2, `ALU_SLL);
        rtype_case("sra",  6'b000011, 2'd2, `ALU_SRA);
        rtype_case("srav", 6'b000111, 2'd1, `ALU_SRA);

        itype_case("addi", 6'b001000, 1'b1, `ALU_ADD);
        itype_case("slti", 6'b001010, 1'b1, `ALU_SLT);
        itype_case("ori",  6'b001101, 1'b0, `ALU_OR);
        itype_case("lui",  6'b001111, 1'b0, `ALU_LUI);

        begin_instr("lw", 6'b100011, 6'd0, 5'd0, 0, 0, 0);
        nxt("lw_addr", ev(4'd4, 0,0,0,0, 0,1,0, 2'd1,2'd2,2'd0,2'd0,2'd0, `ALU_ADD));
        nxt("lw_rd",   ev(4'd5, 0,0,0,0, 1,0,0, 2'd0,2'd0,2'd0,2'd0,2'd0, `ALU_ADD));
        nxt("lw_wb",   ev(4'd6, 0,0,0,1, 0,0,0, 2'd0,2'd0,2'd0,2'd0,2'd1, `ALU_ADD));
        nxt("lw_ret", fetch_v);

        begin_instr("sw", 6'b101011, 6'd0, 5'd0, 0, 0, 0);
        nxt("sw_addr", ev(4'd4, 0,0,0,0, 0,1,0, 2'd1,2'd2,2'd0,2'd0,2'd0, `ALU_ADD));
        nxt("sw_wr",   ev(4'd7, 0,0,1,0, 1,0,0, 2'd0,2'd0,2'd0,2'd0,2'd0, `ALU_ADD));
        nxt("sw_ret", fetch_v);

        branch_case("beq_t",    6'b000100, 5'd0, 1, 0, 0, 1);
        branch_case("beq_nt",   6'b000100, 5'd0, 0, 0, 0, 0);
        branch_case("bne_t",    6'b000101, 5'd0, 0, 0, 0, 1);
        branch_case("bne_nt",   6'b000101, 5'd0, 1, 0, 0, 0);
        branch_case("blez_z",   6'b000110, 5'd0, 0, 0, 1, 1);
        branch_case("blez_pos", 6'b000110, 5'd0, 0, 0, 0, 0);
        branch_case("bgtz_t",   6'b000111, 5'd0, 0, 0, 0, 1);
        branch_case("bgtz_neg", 6'b000111, 5'd0, 0, 1, 0, 0);
        branch_case("bltz_t",   6'b000001, 5'd0, 0, 1, 0, 1);
        branch_case("bltz_nt",  6'b000001, 5'd0, 0, 0, 0, 0);
        branch_case("bgez_t",   6'b000001, 5'd1, 0, 0, 1, 1);
        branch_case("bgez_nt",  6'b000001, 5'd1, 0, 1, 0, 0);

        jump_case("j",    6'b000010, 6'd0,      1'b0, 2'd2, 2'd0, 2'd0);
        jump_case("jal",  6'b000011, 6'd0,      1'b1, 2'd2, 2'd2, 2'd2);
        jump_case("jr",   6'b000000, 6'b001000, 1'b0, 2'd3, 2'd0, 2'd0);
        jump_case("jalr", 6'b000000, 6'b001001, 1'b1, 2'd3, 2'd1, 2'd2);

        // Reset arriving mid-load must abandon the write-back.
        begin_instr("lwrst", 6'b100011, 6'd0, 5'd0, 0, 0, 0);
        nxt("lwrst_addr", ev(4'd4, 0,0,0,0, 0,1,0, 2'd1,2'd2,2'd0,2'd0,2'd0, `ALU_ADD));
        nxt("lwrst_rd",   ev(4'd5, 0,0,0,0, 1,0,0, 2'd0,2'd0,2'd0,2'd0,2'd0, `ALU_ADD));
        rst = 1'b1;
        nxt("lwrst_fetch", rst_v);
        rst = 1'b0;
        #1;
        check("lwrst_release", obs, fetch_v);

        illegal_case("ill_op",    6'b111111, 6'd0,      5'd0);
        illegal_case("ill_funct", 6'b000000, 6'b111111, 5'd0);
        illegal_case("ill_rt",    6'b000001, 6'd0,      5'd5);

        rtype_case("after_ill", 6'b100101, 2'd1, `ALU_OR);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mc_ctrl.md
MC_CTRL -- requirements
Module: mc_ctrl

Interface
REQ-001 SHALL: clk  input  1  sole clock; all state updates on rising edge.
REQ-002 SHALL: rst  input  1  reset, synchronous, active-high.
REQ-003 SHALL: Op  input  6  IR[31:26]; Funct  input  6  IR[5:0]; Rt  input  5  IR[20:16].
REQ-004 SHALL: Zero, A_First, A_Zero  input  1 each  ALU flags: result==0, A[31], A==0.
REQ-005 SHALL: PCWrite, IRWrite, MemWrite, RegWrite, IorD, ExtOp  output  1 each  datapath strobes/selects (ExtOp 1=sign-extend, 0=zero-extend).
REQ-006 SHALL: ALUSrcA  output  2  0=PC, 1=reg A, 2=shamt; ALUSrcB  output  2  0=reg B, 1=const 4, 2=ext imm, 3=ext imm<<2.
REQ-007 SHALL: PCSource  output  2  0=ALU result, 1=ALUOut, 2=jump target, 3=reg A; RegDst  output  2  0=rt, 1=rd, 2=$31; MemtoReg  output  2  0=ALUOut, 1=MDR, 2=PC.
REQ-008 SHALL: ALUOp  output  4  ALU operation, encoded with the shared ALU_* macros from alu_def.v.
REQ-009 SHALL: State  output  4  current FSM state (debug); Illegal  output  1  trap flag.

Function
REQ-010 SHALL: states FETCH, DECODE, EXEC_R, EXEC_I, MEM_ADDR, MEM_RD, MEM_WB, MEM_WR, WB_R, WB_I, BRANCH, JUMP, HALT; all outputs Moore except branch PCWrite (REQ-016).
REQ-011 SHALL: FETCH -- IorD=0, IRWrite=1, ALUSrcA=0, ALUSrcB=1, ALUOp=ADD, PCSource=0, PCWrite=1; next DECODE.
REQ-012 SHALL: DECODE -- ALUSrcA=0, ALUSrcB=3, ALUOp=ADD, ExtOp=1 (branch target into ALUOut); dispatch on Op/Funct.
REQ-013 SHALL: R-type (Op=0) ALU functs add/addu/sub/subu/and/or/xor/nor/slt/sltu -> EXEC_R (ALUSrcA=1, ALUSrcB=0) -> WB_R (RegDst=1, MemtoReg=0, RegWrite=1) -> FETCH; sll/srl/sra use ALUSrcA=2, sllv/srlv/srav use ALUSrcA=1.
REQ-014 SHALL: addi/addiu/slti/sltiu (ExtOp=1), andi/ori/xori/lui (ExtOp=0) -> EXEC_I (ALUSrcA=1, ALUSrcB=2) -> WB_I (RegDst=0, RegWrite=1) -> FETCH.
REQ-015 SHALL: lw 100011: MEM_ADDR (ADD, ALUSrcB=2, ExtOp=1) -> MEM_RD (IorD=1) -> MEM_WB (RegDst=0, MemtoReg=1, RegWrite=1); sw 101011: MEM_ADDR -> MEM_WR (IorD=1, MemWrite=1) -> FETCH.
REQ-016 SHALL: BRANCH -- ALUSrcA=1, ALUSrcB=0, ALUOp=SUB, PCSource=1, PCWrite=condition: beq Zero; bne !Zero; blez A_First|A_Zero; bgtz !A_First&!A_Zero; REGIMM(000001) Rt=0 bltz A_First, Rt=1 bgez !A_First; next FETCH.
REQ-017 SHALL: JUMP -- j PCSource=2; jal PCSource=2, RegDst=2, MemtoReg=2, RegWrite=1; jr PCSource=3; jalr PCSource=3, RegDst=1, MemtoReg=2, RegWrite=1; PCWrite=1; next FETCH.
REQ-018 SHALL: latencies: R/I-ALU 4 cycles, lw 5, sw 4, branch/jump 3.
REQ-019 SHALL: in any state, outputs not listed are 0 (write enables never asserted spuriously).
REQ-020 SHALL: undefined Op, Funct or REGIMM Rt handled per REQ-024.

Reset
REQ-021 SHALL: rst high at a clock edge loads FETCH regardless of current state, including mid-instruction and HALT.
REQ-022 SHALL: while rst high, PCWrite, IRWrite, MemWrite, RegWrite, Illegal forced 0; after rst release the first cycle is FETCH.

Configuration
REQ-023 SHALL: macro MC_CTRL_ILLEGAL_TRAP_EN selects undefined-instruction handling.
REQ-024 SHALL: defined -> DECODE of undefined instruction goes to HALT, Illegal=1, all write enables 0, held until rst; undefined -> DECODE returns to FETCH (NOP, 2 cycles), Illegal tied 0, HALT unreachable.

Verification
REQ-025 SHALL: rst, then Op=0 Funct=100000 -> states FETCH,DECODE,EXEC_R,WB_R; RegWrite=1 RegDst=1 only in WB_R; ALUOp=ADD in EXEC_R.
REQ-026 SHALL: Op=100011 -> 5-cycle sequence ending MEM_WB, MemtoReg=1; Op=101011 -> MemWrite=1 exactly one cycle, RegWrite never 1.
REQ-027 SHALL: Op=000100 with Zero=1 -> PCWrite=1 PCSource=1 in BRANCH; Zero=0 -> PCWrite=0; Op=000001 Rt=0 A_First=1 -> PCWrite=1.
REQ-028 SHALL: Op=000011 -> JUMP with RegDst=2, MemtoReg=2, RegWrite=1, PCSource=2.
REQ-029 SHALL: rst asserted during MEM_RD -> next state FETCH, no RegWrite.
REQ-030 SHALL: Op=111111 -> with macro HALT, Illegal=1 until rst; without, back to FETCH after DECODE.
